// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus bundle.
// Carries both writeback requesters' handshakes, the registered regfile write port, and the
// two read ports with their raw and forwarded data.
//   slave  : the arbiter side (accepts requests, drives write port and forwarded read data)
//   master : the surrounding pipeline / regfile side
interface regfile_wb_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_reg;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_reg;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    logic              RegWrite;
    logic [ADDR_W-1:0] writereg;
    logic [DATA_W-1:0] writedata;

    logic [ADDR_W-1:0] readreg1;
    logic [ADDR_W-1:0] readreg2;
    logic [DATA_W-1:0] rf_readdata1;
    logic [DATA_W-1:0] rf_readdata2;
    logic [DATA_W-1:0] fwd_readdata1;
    logic [DATA_W-1:0] fwd_readdata2;

    modport slave (
        input  req0_valid, req0_reg, req0_data,
        output req0_ready,
        input  req1_valid, req1_reg, req1_data,
        output req1_ready,
        output RegWrite, writereg, writedata,
        input  readreg1, readreg2, rf_readdata1, rf_readdata2,
        output fwd_readdata1, fwd_readdata2
    );

    modport master (
        output req0_valid, req0_reg, req0_data,
        input  req0_ready,
        output req1_valid, req1_reg, req1_data,
        input  req1_ready,
        input  RegWrite, writereg, writedata,
        output readreg1, readreg2, rf_readdata1, rf_readdata2,
        input  fwd_readdata1, fwd_readdata2
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Regfile writeback arbiter.
// Shares the single regfile write port between ALU writeback (requester 0) and load writeback
// (requester 1). One grant per cycle, round-robin (FAIR=1) or req0-first (FAIR=0). The winner
// is registered into a one-cycle output stage; the in-flight write is forwarded onto both read
// ports so reads in the write cycle see the new value.
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   bus          regfile_wb_arbiter_if.slave (requests, write port, read forwarding)
//   conflict_cnt saturating count of cycles with both requesters valid
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned FAIR   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus,
    output logic [CNT_W-1:0]     conflict_cnt
);
    localparam bit Fair = (FAIR != 0);

    logic              grant0, grant1, xfer;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;

    logic              last_q;      // 1: requester 1 won the most recent transfer
    logic              regwrite_q;
    logic [ADDR_W-1:0] writereg_q;
    logic [DATA_W-1:0] writedata_q;
    logic [CNT_W-1:0]  conflict_q, conflict_d;

    // On a tie req0 wins unless round-robin says req0 was the last winner.
    always_comb begin
        grant0   = 1'b0;
        grant1   = 1'b0;
        if (!rst) begin
            grant0 = bus.req0_valid & (~bus.req1_valid | ~Fair | last_q);
            grant1 = bus.req1_valid & ~grant0;
        end
        xfer     = grant0 | grant1;
        sel_reg  = grant1 ? bus.req1_reg  : bus.req0_reg;
        sel_data = grant1 ? bus.req1_data : bus.req0_data;
    end

    always_comb begin
        conflict_d = conflict_q;
        if (bus.req0_valid && bus.req1_valid && (conflict_q != {CNT_W{1'b1}})) begin
            conflict_d = conflict_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q      <= 1'b1;
            regwrite_q  <= 1'b0;
            writereg_q  <= '0;
            writedata_q <= '0;
            conflict_q  <= '0;
        end else begin
            conflict_q <= conflict_d;
            if (xfer) begin
                last_q      <= grant1;
                // r0 writes are accepted and latched but never enabled.
                regwrite_q  <= (sel_reg != '0);
                writereg_q  <= sel_reg;
                writedata_q <= sel_data;
            end else begin
                regwrite_q  <= 1'b0;
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.RegWrite   = regwrite_q;
    assign bus.writereg   = writereg_q;
    assign bus.writedata  = writedata_q;
    assign conflict_cnt   = conflict_q;

    assign bus.fwd_readdata1 = (regwrite_q && (writereg_q == bus.readreg1) && (bus.readreg1 != '0))
                               ? writedata_q : bus.rf_readdata1;
    assign bus.fwd_readdata2 = (regwrite_q && (writereg_q == bus.readreg2) && (bus.readreg2 != '0))
                               ? writedata_q : bus.rf_readdata2;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cnt_f;
    logic [1:0]  cnt_p;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus_f ();
    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus_p ();

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FAIR(1), .CNT_W(16)) u_fair (
        .clk(clk), .rst(rst), .bus(bus_f), .conflict_cnt(cnt_f)
    );
    // Narrow counter so saturation is reachable in a few cycles.
    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FAIR(0), .CNT_W(2)) u_prio (
        .clk(clk), .rst(rst), .bus(bus_p), .conflict_cnt(cnt_p)
    );

    // Both DUTs always see the same request stimulus.
    task automatic drive(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] r1, input logic [31:0] d1);
        bus_f.req0_valid = v0; bus_f.req0_reg = r0; bus_f.req0_data = d0;
        bus_f.req1_valid = v1; bus_f.req1_reg = r1; bus_f.req1_data = d1;
        bus_p.req0_valid = v0; bus_p.req0_reg = r0; bus_p.req0_data = d0;
        bus_p.req1_valid = v1; bus_p.req1_reg = r1; bus_p.req1_data = d1;
    endtask

    task automatic read_ports(input logic [4:0] a1, input logic [31:0] rd1,
                              input logic [4:0] a2, input logic [31:0] rd2);
        bus_f.readreg1 = a1; bus_f.rf_readdata1 = rd1;
        bus_f.readreg2 = a2; bus_f.rf_readdata2 = rd2;
        bus_p.readreg1 = a1; bus_p.rf_readdata1 = rd1;
        bus_p.readreg2 = a2; bus_p.rf_readdata2 = rd2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if ({bus_f.req0_ready, bus_f.req1_ready, bus_p.req0_ready, bus_p.req1_ready} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b required 0000",
                     {bus_f.req0_ready, bus_f.req1_ready, bus_p.req0_ready, bus_p.req1_ready});
        end
        n_checks++;
        if (bus_f.RegWrite !== 1'b0 || bus_f.writereg !== 5'd0 || bus_f.writedata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_wport: got we=%b reg=%0d data=%h required 0/0/0",
                     bus_f.RegWrite, bus_f.writereg, bus_f.writedata);
        end
        n_checks++;
        if (cnt_f !== 16'd0 || cnt_p !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d/%0d required 0/0", cnt_f, cnt_p);
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_single_write();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        #1;
        n_checks++;
        if (bus_f.req0_ready !== 1'b1 || bus_f.req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_ready: got r0=%b r1=%b required 1/0", bus_f.req0_ready, bus_f.req1_ready);
        end
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        n_checks++;
        if (bus_f.RegWrite !== 1'b1 || bus_f.writereg !== 5'd5 || bus_f.writedata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL t1_wport: got we=%b reg=%0d data=%h required 1/5/deadbeef",
                     bus_f.RegWrite, bus_f.writereg, bus_f.writedata);
        end
        step();
        n_checks++;
        if (bus_f.RegWrite !== 1'b0 || bus_f.writereg !== 5'd5 || bus_f.writedata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL t1_hold: got we=%b reg=%0d data=%h required 0/5/deadbeef",
                     bus_f.RegWrite, bus_f.writereg, bus_f.writedata);
        end
    endtask

    task automatic test_round_robin();
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
        do_reset();
        drive(1'b1, 5'd1, 32'h11111111, 1'b1, 5'd2, 32'h22222222);
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus_f.req0_ready !== (i % 2 == 0) || bus_f.req1_ready !== (i % 2 == 1)) begin
                n_fail++;
                $display("FAIL t2_grant%0d: got r0=%b r1=%b required %b/%b", i,
                         bus_f.req0_ready, bus_f.req1_ready, (i % 2 == 0), (i % 2 == 1));
            end
            if (i > 0) begin
                exp_reg  = (i % 2 == 1) ? 5'd1 : 5'd2;
                exp_data = (i % 2 == 1) ? 32'h11111111 : 32'h22222222;
                n_checks++;
                if (bus_f.RegWrite !== 1'b1 || bus_f.writereg !== exp_reg ||
                    bus_f.writedata !== exp_data) begin
                    n_fail++;
                    $display("FAIL t2_wport%0d: got we=%b reg=%0d data=%h required 1/%0d/%h", i,
                             bus_f.RegWrite, bus_f.writereg, bus_f.writedata, exp_reg, exp_data);
                end
            end
            step();
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        n_checks++;
        if (bus_f.RegWrite !== 1'b1 || bus_f.writereg !== 5'd2 || bus_f.writedata !== 32'h22222222) begin
            n_fail++;
            $display("FAIL t2_wport4: got we=%b reg=%0d data=%h required 1/2/22222222",
                     bus_f.RegWrite, bus_f.writereg, bus_f.writedata);
        end
        n_checks++;
        if (cnt_f !== 16'd4) begin
            n_fail++;
            $display("FAIL t2_cnt: got %0d required 4", cnt_f);
        end
        step();
    endtask

    task automatic test_fixed_priority();
        do_reset();
        drive(1'b1, 5'd1, 32'h11111111, 1'b1, 5'd2, 32'h22222222);
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus_p.req0_ready !== 1'b1 || bus_p.req1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL t3_grant%0d: got r0=%b r1=%b required 1/0", i,
                         bus_p.req0_ready, bus_p.req1_ready);
            end
            step();
            n_checks++;
            if (bus_p.RegWrite !== 1'b1 || bus_p.writereg !== 5'd1) begin
                n_fail++;
                $display("FAIL t3_wport%0d: got we=%b reg=%0d required 1/1", i,
                         bus_p.RegWrite, bus_p.writereg);
            end
            if (i == 2) begin
                n_checks++;
                if (cnt_p !== 2'd3) begin
                    n_fail++;
                    $display("FAIL t3_cnt3: got %0d required 3", cnt_p);
                end
            end
        end
        n_checks++;
        if (cnt_p !== 2'd3) begin
            n_fail++;
            $display("FAIL t3_cnt_sat: got %0d required 3", cnt_p);
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
    endtask

    task automatic test_r0_write();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234);
        read_ports(5'd0, 32'hCAFE0001, 5'd0, 32'hCAFE0002);
        #1;
        n_checks++;
        if (bus_f.req1_ready !== 1'b1 || bus_f.req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_ready: got r0=%b r1=%b required 0/1", bus_f.req0_ready, bus_f.req1_ready);
        end
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        n_checks++;
        if (bus_f.RegWrite !== 1'b0 || bus_f.writereg !== 5'd0 || bus_f.writedata !== 32'h1234) begin
            n_fail++;
            $display("FAIL t4_wport: got we=%b reg=%0d data=%h required 0/0/1234",
                     bus_f.RegWrite, bus_f.writereg, bus_f.writedata);
        end
        n_checks++;
        if (bus_f.fwd_readdata1 !== 32'hCAFE0001) begin
            n_fail++;
            $display("FAIL t4_fwd_r0: got %h required cafe0001", bus_f.fwd_readdata1);
        end
        // An r0 write by req0 still moves the pointer, so the next tie goes to req1.
        drive(1'b1, 5'd0, 32'h5555, 1'b0, 5'd0, 32'h0);
        #1;
        step();
        drive(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4);
        #1;
        n_checks++;
        if (bus_f.req0_ready !== 1'b0 || bus_f.req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL t4_last: got r0=%b r1=%b required 0/1", bus_f.req0_ready, bus_f.req1_ready);
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
    endtask

    task automatic test_forwarding();
        drive(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        read_ports(5'd3, 32'h00000033, 5'd7, 32'h0);
        #1;
        n_checks++;
        if (bus_f.fwd_readdata2 !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL t5_fwd2: got %h required a5a5a5a5", bus_f.fwd_readdata2);
        end
        n_checks++;
        if (bus_f.fwd_readdata1 !== 32'h00000033) begin
            n_fail++;
            $display("FAIL t5_nofwd1: got %h required 00000033", bus_f.fwd_readdata1);
        end
        read_ports(5'd7, 32'h00000077, 5'd7, 32'h0);
        #1;
        n_checks++;
        if (bus_f.fwd_readdata1 !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL t5_fwd1: got %h required a5a5a5a5", bus_f.fwd_readdata1);
        end
        step();
        n_checks++;
        if (bus_f.fwd_readdata2 !== 32'h0) begin
            n_fail++;
            $display("FAIL t5_stale: got %h required 00000000", bus_f.fwd_readdata2);
        end
    endtask

    task automatic test_reset_midflight();
        drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0);
        #1;
        step();
        rst = 1'b1;
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
        #1;
        n_checks++;
        if (bus_f.RegWrite !== 1'b1 || bus_f.writereg !== 5'd9) begin
            n_fail++;
            $display("FAIL t6_inflight: got we=%b reg=%0d required 1/9", bus_f.RegWrite, bus_f.writereg);
        end
        n_checks++;
        if ({bus_f.req0_ready, bus_f.req1_ready, bus_p.req0_ready, bus_p.req1_ready} !== 4'b0) begin
            n_fail++;
            $display("FAIL t6_rst_ready: got %b required 0000",
                     {bus_f.req0_ready, bus_f.req1_ready, bus_p.req0_ready, bus_p.req1_ready});
        end
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus_f.RegWrite !== 1'b0 || bus_f.writereg !== 5'd0) begin
            n_fail++;
            $display("FAIL t6_discard: got we=%b reg=%0d required 0/0", bus_f.RegWrite, bus_f.writereg);
        end
        n_checks++;
        if (bus_f.req0_ready !== 1'b1 || bus_f.req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_first_tie: got r0=%b r1=%b required 1/0", bus_f.req0_ready, bus_f.req1_ready);
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        read_ports(5'd0, 32'h0, 5'd0, 32'h0);
        test_reset();
        test_single_write();
        test_round_robin();
        test_fixed_priority();
        test_r0_write();
        test_forwarding();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
